// File: rtl/branch_outcome_tracker.sv
// branch_outcome_tracker: in-flight branch prediction queue with resolve, redirect, flush and statistics.
module branch_outcome_tracker #(
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     pred_valid,
   input  logic                     pred_taken,
   input  logic [ADDR_W-1:0]        pred_target,
   input  logic [ADDR_W-1:0]        pred_fallthrough,
   output logic                     pred_ready,
   input  logic                     res_valid,
   input  logic                     res_taken,
   input  logic [ADDR_W-1:0]        res_target,
   output logic                     mispredict,
   output logic [ADDR_W-1:0]        redirect_pc,
   output logic                     update_valid,
   output logic                     previous_branch_result,
   output logic [$clog2(DEPTH):0]   inflight_count,
   output logic [CNT_W-1:0]         branch_count,
   output logic [CNT_W-1:0]         mispredict_count,
   output logic                     overflow_err,
   output logic                     underflow_err
);
   localparam int PW = $clog2(DEPTH);
   localparam int OW = PW + 1;
   logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
   logic [OW-1:0]     cnt_q, cnt_d;
   logic [DEPTH-1:0]  tk_q;
   logic [ADDR_W-1:0] tg_q [DEPTH];
   logic [ADDR_W-1:0] ft_q [DEPTH];
   logic              full, empty, pop, push, miss;
   logic              mis_q, upd_q, prev_q, ovf_q, unf_q;
   logic [ADDR_W-1:0] rpc_q;
   logic [CNT_W-1:0]  bc_q, mc_q;
   always_comb begin
      full  = cnt_q == OW'(DEPTH);
      empty = cnt_q == '0;
      pop   = res_valid && !empty;
      miss  = pop && ((tk_q[rd_q] != res_taken) || (res_taken && (tg_q[rd_q] != res_target)));
      push  = pred_valid && !full && !miss;
      rd_d  = pop ? rd_q + PW'(1) : rd_q;
      // A mispredict flushes everything younger than the head: writer collapses onto reader.
      wr_d  = miss ? rd_d : (push ? wr_q + PW'(1) : wr_q);
      cnt_d = miss ? '0 : cnt_q + OW'(push) - OW'(pop);
   end
   always_ff @(posedge clk) begin
      if (push) begin
         tk_q[wr_q] <= pred_taken;
         tg_q[wr_q] <= pred_target;
         ft_q[wr_q] <= pred_fallthrough;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q   <= '0;
         rd_q   <= '0;
         cnt_q  <= '0;
         mis_q  <= 1'b0;
         upd_q  <= 1'b0;
         prev_q <= 1'b0;
         rpc_q  <= '0;
         bc_q   <= '0;
         mc_q   <= '0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         mis_q <= miss;
         upd_q <= pop;
         if (pop) prev_q <= res_taken;
         if (miss) rpc_q <= res_taken ? res_target : ft_q[rd_q];
         if (pop && bc_q != '1) bc_q <= bc_q + CNT_W'(1);
         if (miss && mc_q != '1) mc_q <= mc_q + CNT_W'(1);
         if (pred_valid && full && !miss) ovf_q <= 1'b1;
         if (res_valid && empty) unf_q <= 1'b1;
      end
   end
   assign pred_ready             = !full;
   assign inflight_count         = cnt_q;
   assign mispredict             = mis_q;
   assign redirect_pc            = rpc_q;
   assign update_valid           = upd_q;
   assign previous_branch_result = prev_q;
   assign branch_count           = bc_q;
   assign mispredict_count       = mc_q;
   assign overflow_err           = ovf_q;
   assign underflow_err          = unf_q;
endmodule

// File: tb/tb_branch_outcome_tracker.sv
// tb_branch_outcome_tracker: directed checks of branch_outcome_tracker, plus a CNT_W=2 copy for saturation.
module tb_branch_outcome_tracker;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pred_valid = 1'b0, pred_taken = 1'b0;
   logic [31:0] pred_target = '0, pred_fallthrough = '0;
   logic        res_valid = 1'b0, res_taken = 1'b0;
   logic [31:0] res_target = '0;
   logic        pred_ready, mispredict, update_valid, prev, ovf, unf;
   logic [31:0] redirect_pc;
   logic [2:0]  inflight;
   logic [15:0] bcnt, mcnt;
   logic        s_ready, s_mis, s_upd, s_prev, s_ovf, s_unf;
   logic [31:0] s_rpc;
   logic [2:0]  s_inflight;
   logic [1:0]  s_bcnt, s_mcnt;
   int          n_chk = 0;
   int          n_fail = 0;
   always #5 clk = ~clk;
   branch_outcome_tracker #(.ADDR_W(32), .DEPTH(4), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_taken(pred_taken),
      .pred_target(pred_target), .pred_fallthrough(pred_fallthrough), .pred_ready(pred_ready),
      .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
      .mispredict(mispredict), .redirect_pc(redirect_pc), .update_valid(update_valid),
      .previous_branch_result(prev), .inflight_count(inflight), .branch_count(bcnt),
      .mispredict_count(mcnt), .overflow_err(ovf), .underflow_err(unf));
   branch_outcome_tracker #(.ADDR_W(32), .DEPTH(4), .CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_taken(pred_taken),
      .pred_target(pred_target), .pred_fallthrough(pred_fallthrough), .pred_ready(s_ready),
      .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
      .mispredict(s_mis), .redirect_pc(s_rpc), .update_valid(s_upd),
      .previous_branch_result(s_prev), .inflight_count(s_inflight), .branch_count(s_bcnt),
      .mispredict_count(s_mcnt), .overflow_err(s_ovf), .underflow_err(s_unf));
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic push(input logic tk, input logic [31:0] tg, input logic [31:0] ft);
      pred_valid = 1'b1; pred_taken = tk; pred_target = tg; pred_fallthrough = ft;
   endtask
   task automatic resolve(input logic tk, input logic [31:0] tg);
      res_valid = 1'b1; res_taken = tk; res_target = tg;
   endtask
   task automatic idle();
      pred_valid = 1'b0; res_valid = 1'b0;
   endtask
   initial begin
      rst = 1'b1; step(); rst = 1'b0;
      chk("rst_ready", pred_ready, 1); chk("rst_inflight", inflight, 0);
      chk("rst_mis", mispredict, 0); chk("rst_upd", update_valid, 0);
      chk("rst_prev", prev, 0); chk("rst_rpc", redirect_pc, 0);
      chk("rst_bcnt", bcnt, 0); chk("rst_mcnt", mcnt, 0);
      chk("rst_ovf", ovf, 0); chk("rst_unf", unf, 0);
      // correct taken prediction
      push(1, 32'h100, 32'h84); step(); idle();
      chk("t1_inflight", inflight, 1);
      resolve(1, 32'h100); step(); idle();
      chk("t1_upd", update_valid, 1); chk("t1_mis", mispredict, 0);
      chk("t1_prev", prev, 1); chk("t1_bcnt", bcnt, 1); chk("t1_inflight0", inflight, 0);
      step();
      chk("t1_upd_pulse", update_valid, 0);
      // direction mispredict flushes younger entries
      push(1, 32'h300, 32'h44); step();
      push(0, 32'h0, 32'h50); step();
      push(0, 32'h0, 32'h60); step(); idle();
      chk("t2_inflight3", inflight, 3);
      resolve(0, 32'h0); step(); idle();
      chk("t2_mis", mispredict, 1); chk("t2_rpc", redirect_pc, 32'h44);
      chk("t2_inflight", inflight, 0); chk("t2_mcnt", mcnt, 1);
      chk("t2_bcnt", bcnt, 2); chk("t2_prev", prev, 0); chk("t2_s_mcnt", s_mcnt, 1);
      step();
      chk("t2_mis_pulse", mispredict, 0); chk("t2_rpc_hold", redirect_pc, 32'h44);
      chk("t2_upd_pulse", update_valid, 0);
      // target mispredict
      push(1, 32'h200, 32'h1f4); step(); idle();
      resolve(1, 32'h204); step(); idle();
      chk("t3_mis", mispredict, 1); chk("t3_rpc", redirect_pc, 32'h204);
      chk("t3_mcnt", mcnt, 2); chk("t3_bcnt", bcnt, 3); chk("t3_s_mcnt", s_mcnt, 2);
      // full queue behaviour
      push(0, 32'h0, 32'h10); step();
      push(0, 32'h0, 32'h14); step();
      push(0, 32'h0, 32'h18); step();
      push(0, 32'h0, 32'h1c); step(); idle();
      chk("t4_ready", pred_ready, 0); chk("t4_inflight4", inflight, 4); chk("t4_ovf0", ovf, 0);
      push(0, 32'h0, 32'h99); step(); idle();
      chk("t4_ovf", ovf, 1); chk("t4_inflight_hold", inflight, 4);
      push(0, 32'h0, 32'h98); resolve(0, 32'h0); step(); idle();
      chk("t4_full_pop", inflight, 3); chk("t4_full_pop_mis", mispredict, 0);
      push(0, 32'h0, 32'h20); resolve(0, 32'h0); step(); idle();
      chk("t4_pushpop", inflight, 3); chk("t4_pushpop_upd", update_valid, 1);
      chk("t4_bcnt", bcnt, 5);
      push(0, 32'h0, 32'h24); resolve(1, 32'h500); step(); idle();
      chk("t4_flush_mis", mispredict, 1); chk("t4_flush_rpc", redirect_pc, 32'h500);
      chk("t4_flush_inflight", inflight, 0); chk("t4_flush_mcnt", mcnt, 3);
      chk("t4_flush_bcnt", bcnt, 6); chk("t4_flush_ready", pred_ready, 1);
      // empty resolve
      resolve(1, 32'h0); step(); idle();
      chk("t5_unf", unf, 1); chk("t5_upd", update_valid, 0); chk("t5_mis", mispredict, 0);
      chk("t5_bcnt", bcnt, 6); chk("t5_mcnt", mcnt, 3);
      push(1, 32'h600, 32'h604); resolve(1, 32'h600); step(); idle();
      chk("t5_push_empty", inflight, 1); chk("t5_push_empty_upd", update_valid, 0);
      // saturation on the narrow-counter copy
      resolve(0, 32'h0); step(); idle();
      chk("t6_rpc", redirect_pc, 32'h604); chk("t6_mcnt", mcnt, 4); chk("t6_bcnt", bcnt, 7);
      push(1, 32'h700, 32'h704); step(); idle();
      resolve(1, 32'h708); step(); idle();
      chk("t6_rpc2", redirect_pc, 32'h708); chk("t6_mcnt5", mcnt, 5);
      chk("t6_s_mcnt_sat", s_mcnt, 3); chk("t6_s_bcnt_sat", s_bcnt, 3);
      // reset with entries in flight and a same-cycle resolve
      push(0, 32'h0, 32'h30); step();
      push(0, 32'h0, 32'h34); step(); idle();
      chk("t7_inflight2", inflight, 2);
      rst = 1'b1; resolve(0, 32'h0); push(0, 32'h0, 32'h38); step(); rst = 1'b0; idle();
      chk("t7_upd", update_valid, 0); chk("t7_mis", mispredict, 0);
      chk("t7_inflight", inflight, 0); chk("t7_ready", pred_ready, 1);
      chk("t7_rpc", redirect_pc, 0); chk("t7_prev", prev, 0);
      chk("t7_bcnt", bcnt, 0); chk("t7_mcnt", mcnt, 0);
      chk("t7_ovf", ovf, 0); chk("t7_unf", unf, 0); chk("t7_s_mcnt", s_mcnt, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/branch_outcome_tracker.md
# branch_outcome_tracker

Tracks in-flight conditional-branch predictions between fetch/decode and execute in the pipelined RISC-V core, and closes the loop for the dynamic predictor. Holds each issued prediction in an ordered queue, retires it against the actual outcome from EX, and reports mispredictions with the redirect PC and a pipeline flush. Drives `previous_branch_result` back to the predictor and keeps saturating branch/mispredict statistics.

## Interface
- `ADDR_W`, 32, PC width
- `DEPTH`, 4, max in-flight predictions (power of two, ≥2)
- `CNT_W`, 16, statistics counter width

- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `pred_valid`  in  1  decode issues a branch prediction this cycle
- `pred_taken`  in  1  predicted direction (predictor's `branch_decision`)
- `pred_target`  in  ADDR_W  predicted taken target
- `pred_fallthrough`  in  ADDR_W  PC+4 of the branch
- `pred_ready`  out  1  queue can accept (= not full)
- `res_valid`  in  1  EX resolves the oldest branch this cycle
- `res_taken`  in  1  actual direction
- `res_target`  in  ADDR_W  actual taken target
- `mispredict`  out  1  one-cycle flush/redirect pulse
- `redirect_pc`  out  ADDR_W  correct next PC, valid with `mispredict`
- `update_valid`  out  1  one-cycle pulse: predictor should train
- `previous_branch_result`  out  1  last resolved direction, held until next resolve
- `inflight_count`  out  $clog2(DEPTH)+1  queue occupancy
- `branch_count`  out  CNT_W  resolved branches, saturating
- `mispredict_count`  out  CNT_W  mispredictions, saturating
- `overflow_err`  out  1  sticky: push attempted while full
- `underflow_err`  out  1  sticky: resolve attempted while empty

## Operation
- Queue: circular FIFO of DEPTH entries {taken, target, fallthrough}; wrapping read/write pointers; push accepted iff `pred_valid && pred_ready`; pop iff `res_valid && !empty`.
- Compare on pop against head entry: mispredict = (head.taken != res_taken) || (res_taken && head.target != res_target).
- Redirect: `res_taken ? res_target : head.fallthrough`.
- Mispredict flush: all entries younger than head are discarded. Queue becomes empty at the same edge as the pop. A push in the same cycle is dropped as wrong-path: not counted and not flagged.
- Correct prediction: normal pop. Simultaneous push proceeds and occupancy is unchanged.
- No bypass. A push and a resolve in the same cycle on an empty queue raise `underflow_err`, and the push is still accepted.
- Full: `pred_ready`=0. A pop in the same cycle does not enable the push. `pred_valid` while full sets `overflow_err`, and the entry is discarded.
- Empty resolve: no pop, no pulses, counters unchanged, `underflow_err` set.
- Counters: `branch_count` +1 per valid pop. `mispredict_count` +1 per mispredict. Both hold at all-ones.
- Reset: synchronous clear of pointers, occupancy, pulses, `redirect_pc`, `previous_branch_result`, counters and sticky errors. Any in-flight entries are lost. Reset wins over a same-cycle push or resolve.

## Timing
- All outputs are registered except `pred_ready` and `inflight_count`, which are combinational from state.
- Reset values: every output is 0, except `pred_ready`=1.
- Resolve at edge N (`res_valid` sampled, non-empty):
  - at N+1: `update_valid`=1 for one cycle; `previous_branch_result`=`res_taken`; counters updated.
  - if mispredicted, at N+1: `mispredict`=1 for one cycle and `redirect_pc` valid; `inflight_count` already 0.
- `redirect_pc` holds its last value after the pulse.
- A push at edge N is visible in `inflight_count` at N+1.
- Back-to-back resolves every cycle are supported at full throughput.

## Test plan
- Reset, then push taken/target 0x100/ft 0x84; resolve taken 0x100 -> next cycle `update_valid`=1, `mispredict`=0, `previous_branch_result`=1, `branch_count`=1.
- Push 3 entries; resolve the first as not-taken against predicted taken (ft 0x44) -> `mispredict` pulse, `redirect_pc`=0x44, `inflight_count`=0, `mispredict_count`=1; the other 2 entries are never popped.
- Predict taken to 0x200; resolve taken to 0x204 -> mispredict, `redirect_pc`=0x204.
- Fill 4 entries -> `pred_ready`=0. Push a 5th -> `overflow_err`=1, occupancy stays 4. Push + correct resolve on a 3-entry queue -> occupancy stays 3.
- Resolve on an empty queue -> `underflow_err`=1, no pulses, counters unchanged. With CNT_W=2, run 5 mispredicts -> `mispredict_count` saturates at 3.
- Assert `rst` with 2 entries in flight and a same-cycle resolve -> next cycle all outputs at reset values, no `update_valid` pulse.
